div_result_disp: RTL and testbench
==================================

DIV_RESULT_DISP -- requirements
Module: div_result_disp

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter SCAN_DIV, default 50000, SHALL set the number of clk cycles each digit is displayed (minimum 2).
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 load  input  1  one-cycle strobe; value and err are sampled when it is high.
REQ-006 value  input  8  divider result, fixed-point, unit 0.1 (e.g. 123 = 12.3).
REQ-007 err  input  1  divide-by-zero flag accompanying value.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when the new digits are visible.
REQ-010 seg  output  8  active-low segments: seg[7]=dp, seg[6:0]=g..a.
REQ-011 an  output  4  active-low digit enables; an[0] is the rightmost digit.

Function
REQ-012 The FSM SHALL have two states: IDLE and CONV.
REQ-013 In IDLE, load=1 SHALL load a 20-bit shift register with {12'b0,value}, latch err into err_pend, clear the iteration counter, and go to CONV.
REQ-014 In CONV, each cycle SHALL add 3 to every BCD nibble that is >=5, then shift the register left by 1 (double-dabble).
REQ-015 After exactly 8 CONV cycles, the block SHALL do the following at the same edge: latch hundreds/tens/ones into the display registers, latch err_pend into err_disp, pulse done, and return to IDLE.
REQ-016 Timing: load is sampled at edge E0, busy is high from E0 to E8, digits update and done rises at E8, and done falls at E9.
REQ-017 load while busy=1 SHALL be ignored; the in-flight conversion and its result SHALL NOT be affected.
REQ-018 load in the same cycle that done is high SHALL be accepted, because the FSM is in IDLE.
REQ-019 The display registers SHALL hold their last values until the next done.
REQ-020 The scan prescaler SHALL count 0..SCAN_DIV-1 and wrap; on each wrap, the digit select SHALL advance 0->1->2->3->0.
REQ-021 The selected digit SHALL drive its an bit low, and all other an bits SHALL be high.
REQ-022 Digit 0 SHALL show ones (tenths), with dp off.
REQ-023 Digit 1 SHALL show tens, with dp on.
REQ-024 Digit 2 SHALL show hundreds, with dp off.
REQ-025 Digit 3 SHALL always be blank (seg=8'hFF).
REQ-026 When err_disp=1, digits 0-2 SHALL show a minus sign (only segment g lit, seg=8'hBF), and dp SHALL be off.
REQ-027 The 7-segment decode SHALL cover 0-9 in standard active-low patterns, e.g. 0=8'hC0, 1=8'hF9, 8=8'h80.
REQ-028 The full range 0..255 SHALL display correctly; 255 SHALL read "25.5".
REQ-029 Scanning SHALL continue unaffected during conversion.

Reset
REQ-030 While rst=1, the block SHALL hold the following values, all of which are also the post-reset values:
- state IDLE
- busy=0, done=0
- shift register, counters, display registers, err_pend and err_disp all 0
- digit select 0
- an=4'hF, seg=8'hFF
REQ-031 Reset asserted mid-conversion SHALL abort the conversion, and no done SHALL follow.
REQ-032 After reset, the display SHALL not light until the first prescaler wrap; digit registers then display 0, so the first digit shown is "0".

Configuration
REQ-033 When the macro LEADING_ZERO_BLANK_EN is defined, digit 2 SHALL be blank (8'hFF) whenever hundreds=0 and err_disp=0.
REQ-034 Digit 1 SHALL never be blanked, so value 5 SHALL read " 0.5".
REQ-035 When LEADING_ZERO_BLANK_EN is undefined, digit 2 SHALL always show its digit, e.g. value 5 reads "00.5".

Verification (SCAN_DIV=4)
REQ-036 Scenario 1: load with value=123 -> busy is high for 8 cycles, done pulses once, and the scan shows an=1110/seg=B0 ("3"), an=1101/seg=24 ("2."), an=1011/seg=F9 ("1"), an=0111/seg=FF.
REQ-037 Scenario 2: value=255, then value=0 -> the display reads "25.5", then "00.0" (or " 0.0" with LEADING_ZERO_BLANK_EN defined).
REQ-038 Scenario 3: load with value=45, then load with value=99 three cycles later -> the second load is ignored, exactly one done occurs, and the display reads "04.5".
REQ-039 Scenario 4: load with err=1 and value=77 -> digits 0-2 show seg=BF, and digit 3 shows seg=FF.
REQ-040 Scenario 5: rst asserted 4 cycles after load -> busy=0, no done follows, and an=F/seg=FF while rst is held.
REQ-041 Scenario 6: load asserted in the same cycle as done -> the second conversion starts and completes 8 cycles later with the new value.

Source files
------------

// File: rtl/div_result_disp_if.sv
`default_nettype none
// ============================================================================
// Module      : div_result_disp_if
// Description : Load/result and 7-segment display bundle for div_result_disp.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_result_disp_if;
    logic       load;
    logic [7:0] value;
    logic       err;
    logic       busy;
    logic       done;
    logic [7:0] seg;
    logic [3:0] an;

    modport master (
        output load, value, err,
        input  busy, done, seg, an
    );

    modport slave (
        input  load, value, err,
        output busy, done, seg, an
    );
endinterface
`default_nettype wire

// File: rtl/div_result_disp.sv
`default_nettype none
// ============================================================================
// Module      : div_result_disp
// Description : Converts an 8-bit 0.1-unit result to BCD by double-dabble and
//               scans it onto a 4-digit active-low 7-segment display.
//               Optional macro LEADING_ZERO_BLANK_EN blanks a zero hundreds digit.
// Revision    : 1.0 - initial release
// ============================================================================
module div_result_disp #(
    parameter int SCAN_DIV = 50000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    div_result_disp_if.slave   bus
);

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] c_LAST    = PW'(SCAN_DIV - 1);
    localparam logic [7:0]    c_BLANK   = 8'hFF;
    localparam logic [7:0]    c_MINUS   = 8'hBF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t        state_q;
    logic [19:0]   sr_q;
    logic [19:0]   sr_adj;
    logic [19:0]   sr_d;
    logic [2:0]    cnt_q;
    logic          err_pend_q;
    logic          err_disp_q;
    logic [3:0]    hund_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic          busy_q;
    logic          done_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    sel_q;
    logic          lit_q;
    logic [3:0]    an_q;
    logic [3:0]    an_d;
    logic [7:0]    seg_q;
    logic [7:0]    seg_d;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // One double-dabble step: correct each BCD nibble, then shift.
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[11:8]  >= 4'd5) sr_adj[11:8]  = sr_q[11:8]  + 4'd3;
        if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
        if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
        sr_d = {sr_adj[18:0], 1'b0};
    end

    always_comb begin
        an_d  = 4'hF;
        seg_d = c_BLANK;
        case (sel_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = err_disp_q ? c_MINUS : seg7(ones_q);
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = err_disp_q ? c_MINUS : (seg7(tens_q) & 8'h7F);
            end
            2'd2: begin
                an_d  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                if (err_disp_q)           seg_d = c_MINUS;
                else if (hund_q == 4'd0)  seg_d = c_BLANK;
                else                      seg_d = seg7(hund_q);
`else
                seg_d = err_disp_q ? c_MINUS : seg7(hund_q);
`endif
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = c_BLANK;
            end
        endcase
        // Dark until the first prescaler wrap after reset.
        if (!lit_q) begin
            an_d  = 4'hF;
            seg_d = c_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            err_disp_q <= 1'b0;
            hund_q     <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            presc_q    <= '0;
            sel_q      <= '0;
            lit_q      <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= c_BLANK;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        sr_q       <= {12'b0, bus.value};
                        err_pend_q <= bus.err;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        hund_q     <= sr_d[19:16];
                        tens_q     <= sr_d[15:12];
                        ones_q     <= sr_d[11:8];
                        err_disp_q <= err_pend_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (presc_q == c_LAST) begin
                presc_q <= '0;
                sel_q   <= sel_q + 2'd1;
                lit_q   <= 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_div_result_disp.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_result_disp
// Description : Directed vector bench for div_result_disp with SCAN_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_result_disp;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    div_result_disp_if bus ();

    div_result_disp #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] c_HZ = 8'hFF;
`else
    localparam logic [7:0] c_HZ = 8'hC0;
`endif

    typedef struct {
        logic [7:0] v;
        logic       e;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples busy/done on the negedges following the load edge E0.
    task automatic count_conv(input int exp_nb, input int exp_nd, input int exp_pos);
        int nb, nd, pos;
        nb = 0; nd = 0; pos = -1;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy) nb++;
            if (bus.done) begin nd++; pos = i; end
            @(negedge clk);
        end
        chk("busy_cycles", nb, exp_nb);
        chk("done_count", nd, exp_nd);
        chk("done_pos", pos, exp_pos);
    endtask

    task automatic do_load(input logic [7:0] v, input logic e);
        @(negedge clk);
        bus.load = 1'b1; bus.value = v; bus.err = e;
        @(negedge clk);
        bus.load = 1'b0; bus.value = 8'hEE; bus.err = 1'b0;
    endtask

    task automatic check_disp(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
        logic [7:0] exp_seg [4];
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = 8'hFF;
        for (int d = 0; d < 4; d++) begin
            logic [3:0] tgt;
            int k;
            tgt = ~(4'b0001 << d);
            k = 0;
            while (bus.an !== tgt && k < 48) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("an_d%0d", d), int'(bus.an), int'(tgt));
            chk($sformatf("seg_d%0d", d), int'(bus.seg), int'(exp_seg[d]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        total = 0; bad = 0;
        bus.load = 1'b0; bus.value = 8'h00; bus.err = 1'b0;

        vecs[0] = '{v: 8'd123, e: 1'b0, s0: 8'hB0, s1: 8'h24, s2: 8'hF9};
        vecs[1] = '{v: 8'd255, e: 1'b0, s0: 8'h92, s1: 8'h12, s2: 8'hA4};
        vecs[2] = '{v: 8'd0,   e: 1'b0, s0: 8'hC0, s1: 8'h40, s2: c_HZ};
        vecs[3] = '{v: 8'd5,   e: 1'b0, s0: 8'h92, s1: 8'h40, s2: c_HZ};
        vecs[4] = '{v: 8'd77,  e: 1'b1, s0: 8'hBF, s1: 8'hBF, s2: 8'hBF};
        vecs[5] = '{v: 8'd200, e: 1'b0, s0: 8'hC0, s1: 8'h40, s2: 8'hA4};
        vecs[6] = '{v: 8'd99,  e: 1'b0, s0: 8'h90, s1: 8'h10, s2: c_HZ};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_an", int'(bus.an), 'hF);
        chk("rst_seg", int'(bus.seg), 'hFF);
        rst = 1'b0;
        @(negedge clk);
        chk("pre_wrap_an", int'(bus.an), 'hF);
        check_disp(8'hC0, 8'h40, c_HZ);

        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].v, vecs[i].e);
            count_conv(8, 1, 8);
            check_disp(vecs[i].s0, vecs[i].s1, vecs[i].s2);
        end

        // Second load three cycles into a conversion is ignored.
        do_load(8'd45, 1'b0);
        begin
            int nb, nd;
            nb = 0; nd = 0;
            for (int i = 0; i < 16; i++) begin
                if (bus.busy) nb++;
                if (bus.done) nd++;
                bus.load  = (i == 2);
                bus.value = (i == 2) ? 8'd99 : 8'hEE;
                @(negedge clk);
            end
            bus.load = 1'b0;
            chk("ovl_busy_cycles", nb, 8);
            chk("ovl_done_count", nd, 1);
        end
        check_disp(8'h92, 8'h19, c_HZ);

        // Load in the same cycle as done starts a fresh conversion.
        do_load(8'd10, 1'b0);
        k = 0;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_first_done", int'(bus.done), 1);
        bus.load = 1'b1; bus.value = 8'd200;
        @(negedge clk);
        bus.load = 1'b0; bus.value = 8'hEE;
        count_conv(8, 1, 8);
        check_disp(8'hC0, 8'h40, 8'hA4);

        // Reset mid-conversion aborts it.
        do_load(8'd50, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_busy", int'(bus.busy), 0);
            chk("mid_rst_an", int'(bus.an), 'hF);
            chk("mid_rst_seg", int'(bus.seg), 'hFF);
        end
        rst = 1'b0;
        count_conv(0, 0, -1);
        check_disp(8'hC0, 8'h40, c_HZ);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
